// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug snapshot serializer.
// DEBUG_SNAPSHOT_CHECKSUM_EN selects the trailing XOR checksum byte.
package debug_pkg;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic int ch_bytes(
    input int ch_bits,
    input int uart_bits
  );
    return (ch_bits + uart_bits - 1) / uart_bits;
  endfunction

endpackage

// File: rtl/debug_snapshot_tx_if.sv
// UART byte handshake between the snapshot serializer and the transmitter.
// Signal names are taken from the serializer's point of view.
interface debug_snapshot_tx_if #(
  parameter int UART_BITS = 8
) ();

  logic                 o_tx_start;
  logic [UART_BITS-1:0] o_tx_data;
  logic                 i_tx_done;

  modport master (
    output o_tx_start,
    output o_tx_data,
    input  i_tx_done
  );

  modport slave (
    input  o_tx_start,
    input  o_tx_data,
    output i_tx_done
  );

endinterface

// File: rtl/debug_byte_sel.sv
// Picks one UART-sized byte out of the captured snapshot.
// Channels are zero-padded up to a whole number of bytes.
module debug_byte_sel
  import debug_pkg::*;
#(
  parameter int UART_BITS = 8,
  parameter int NUM_CH    = 4,
  parameter int CH_BITS   = 32,
  localparam int CHB      = ch_bytes(CH_BITS, UART_BITS),
  localparam int BCW      = $clog2(CHB + 1),
  localparam int CIW      = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH*CH_BITS-1:0] i_snap,
  input  logic [CIW-1:0]            i_ch,
  input  logic [BCW-1:0]            i_byte,
  output logic [UART_BITS-1:0]      o_byte
);

  logic [CHB*UART_BITS-1:0] w_pad;

  always_comb begin
    w_pad = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CIW'(k) == i_ch) begin
        w_pad[CH_BITS-1:0] = i_snap[k*CH_BITS +: CH_BITS];
      end
    end
  end

  always_comb begin
    o_byte = '0;
    for (int b = 0; b < CHB; b++) begin
      if (BCW'(b) == i_byte) begin
        o_byte = w_pad[b*UART_BITS +: UART_BITS];
      end
    end
  end

endmodule

// File: rtl/debug_snapshot_tx.sv
// Captures a multi-channel snapshot and streams masked channels to a UART.
// Define DEBUG_SNAPSHOT_CHECKSUM_EN to append an XOR checksum byte.
module debug_snapshot_tx
  import debug_pkg::*;
#(
  parameter int UART_BITS = 8,
  parameter int NUM_CH    = 4,
  parameter int CH_BITS   = 32,
  parameter logic [UART_BITS-1:0] SYNC_BYTE =
    UART_BITS'(SYNC_BYTE_DFLT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [NUM_CH-1:0]         i_ch_mask,
  input  logic [NUM_CH*CH_BITS-1:0] i_channels,
  output logic                      o_busy,
  output logic                      o_done,
  debug_snapshot_tx_if.master       tx
);

  localparam int CHB = ch_bytes(CH_BITS, UART_BITS);
  localparam int BCW = $clog2(CHB + 1);
  localparam int CIW = $clog2(NUM_CH + 1);

  state_t                    r_state;
  logic [NUM_CH*CH_BITS-1:0] r_snap;
  logic [NUM_CH-1:0]         r_mask;
  logic [CIW-1:0]            r_ch;
  logic [BCW-1:0]            r_byte;
  logic                      r_hdr;
  logic                      r_tx_start;
  logic [UART_BITS-1:0]      r_tx_data;
  logic                      r_busy;
  logic                      r_done;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
  logic [UART_BITS-1:0]      r_csum;
  logic                      r_csum_sent;
`endif

  logic                      w_found;
  logic [CIW-1:0]            w_next_ch;
  logic [UART_BITS-1:0]      w_byte;

  // lowest enabled channel at or above the current index
  always_comb begin
    w_found   = 1'b0;
    w_next_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (r_mask[k] && (CIW'(k) >= r_ch)) begin
        w_found   = 1'b1;
        w_next_ch = CIW'(k);
      end
    end
  end

  debug_byte_sel #(
    .UART_BITS (UART_BITS),
    .NUM_CH    (NUM_CH),
    .CH_BITS   (CH_BITS)
  ) u_sel (
    .i_snap (r_snap),
    .i_ch   (w_next_ch),
    .i_byte (r_byte),
    .o_byte (w_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_snap      <= '0;
      r_mask      <= '0;
      r_ch        <= '0;
      r_byte      <= '0;
      r_hdr       <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
      r_csum      <= '0;
      r_csum_sent <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_snap      <= i_channels;
            r_mask      <= i_ch_mask;
            r_ch        <= '0;
            r_byte      <= '0;
            r_hdr       <= 1'b0;
            r_busy      <= 1'b1;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
            r_csum      <= '0;
            r_csum_sent <= 1'b0;
`endif
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_WAIT;
          if (!r_hdr) begin
            r_hdr      <= 1'b1;
            r_tx_start <= 1'b1;
            r_tx_data  <= SYNC_BYTE;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
            r_csum     <= r_csum ^ SYNC_BYTE;
`endif
          end else if (w_found) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
            r_csum     <= r_csum ^ w_byte;
`endif
            if (r_byte == BCW'(CHB - 1)) begin
              r_byte <= '0;
              r_ch   <= w_next_ch + 1'b1;
            end else begin
              r_byte <= r_byte + 1'b1;
              r_ch   <= w_next_ch;
            end
`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
          end else if (!r_csum_sent) begin
            r_csum_sent <= 1'b1;
            r_tx_start  <= 1'b1;
            r_tx_data   <= r_csum;
`endif
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_WAIT: begin
          if (tx.i_tx_done) begin
            r_state <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx.o_tx_start = r_tx_start;
  assign tx.o_tx_data  = r_tx_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_debug_snapshot_tx.sv
// Randomized bench for debug_snapshot_tx: 32-bit and 12-bit channel builds
// run side by side against a frame-level reference model.
module tb_debug_snapshot_tx;

`ifdef DEBUG_SNAPSHOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [3:0]   i_ch_mask;
  logic [127:0] i_channels;
  logic [47:0]  i_ch12;
  logic         busy_a, done_a, busy_b, done_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int dly;
  int raise_a, raise_b;
  bit idle_a = 1'b1;
  bit idle_b = 1'b1;
  bit aborted;
  logic [7:0] cap_a[$], cap_b[$];
  logic [7:0] exp_a[$], exp_b[$];
  logic [7:0] d_a, d_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign i_ch12 = {i_channels[96 +: 12], i_channels[64 +: 12],
                   i_channels[32 +: 12], i_channels[0 +: 12]};

  debug_snapshot_tx_if #(.UART_BITS(8)) tx_a ();
  debug_snapshot_tx_if #(.UART_BITS(8)) tx_b ();

  debug_snapshot_tx #(
    .UART_BITS(8), .NUM_CH(4), .CH_BITS(32), .SYNC_BYTE(8'hA5)
  ) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_ch_mask(i_ch_mask),
    .i_channels(i_channels), .o_busy(busy_a), .o_done(done_a),
    .tx(tx_a.master)
  );

  debug_snapshot_tx #(
    .UART_BITS(8), .NUM_CH(4), .CH_BITS(12), .SYNC_BYTE(8'hA5)
  ) u_dut12 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_ch_mask(i_ch_mask),
    .i_channels(i_ch12), .o_busy(busy_b), .o_done(done_b),
    .tx(tx_b.master)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference frame: header, enabled channels LSB byte first, checksum
  task automatic build(input logic [127:0] ch, input logic [3:0] m,
                       input int cb, input bit sel);
    logic [7:0]  tq[$];
    logic [7:0]  cs, bt;
    logic [31:0] v;
    int nb;
    nb = (cb + 7) / 8;
    tq.push_back(8'hA5);
    cs = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        v = ch[k*32 +: 32];
        if (cb < 32) v = v & ((32'd1 << cb) - 32'd1);
        for (int b = 0; b < nb; b++) begin
          bt = 8'(v >> (8 * b));
          tq.push_back(bt);
          cs = cs ^ bt;
        end
      end
    end
    if (CSUM) tq.push_back(cs);
    if (sel) exp_b = tq;
    else exp_a = tq;
  endtask

  initial begin : resp_a
    tx_a.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && tx_a.o_tx_start) begin
        idle_a = 1'b0;
        d_a = tx_a.o_tx_data;
        cap_a.push_back(d_a);
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (rst && !aborted) begin
            chk("hold_a", tx_a.o_tx_data, d_a);
            chk("pulse_a", tx_a.o_tx_start, 1'b0);
          end
        end
        tx_a.i_tx_done = 1'b1;
        raise_a = cyc;
        @(negedge clk);
        tx_a.i_tx_done = 1'b0;
        idle_a = 1'b1;
      end
    end
  end

  initial begin : resp_b
    tx_b.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && tx_b.o_tx_start) begin
        idle_b = 1'b0;
        d_b = tx_b.o_tx_data;
        cap_b.push_back(d_b);
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          if (rst && !aborted) begin
            chk("hold_b", tx_b.o_tx_data, d_b);
            chk("pulse_b", tx_b.o_tx_start, 1'b0);
          end
        end
        tx_b.i_tx_done = 1'b1;
        raise_b = cyc;
        @(negedge clk);
        tx_b.i_tx_done = 1'b0;
        idle_b = 1'b1;
      end
    end
  end

  task automatic run_frame(input logic [127:0] ch, input logic [3:0] m,
                           input bit disturb);
    int t;
    bit got_a, got_b;
    @(negedge clk);
    cap_a.delete();
    cap_b.delete();
    build(ch, m, 32, 1'b0);
    build(ch, m, 12, 1'b1);
    i_channels = ch;
    i_ch_mask  = m;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    chk("busy_a", busy_a, 1'b1);
    chk("sync_start", tx_a.o_tx_start, 1'b1);
    chk("sync_data", tx_a.o_tx_data, 8'hA5);
    t = 0;
    got_a = 1'b0;
    got_b = 1'b0;
    while (!(got_a && got_b) && t < 3000) begin
      @(negedge clk);
      t++;
      i_start = 1'b0;
      if (disturb && t == 3 && busy_a && !done_a && busy_b && !done_b) begin
        i_start    = 1'b1;
        i_channels = ~ch;
        i_ch_mask  = ~m;
      end
      if (done_a && !got_a) begin
        got_a = 1'b1;
        chk("done_lat_a", cyc - raise_a, 2);
      end
      if (done_b && !got_b) begin
        got_b = 1'b1;
        chk("done_lat_b", cyc - raise_b, 2);
      end
    end
    i_start = 1'b0;
    chk("timeout_a", got_a, 1'b1);
    chk("timeout_b", got_b, 1'b1);
    @(negedge clk);
    chk("end_busy_a", busy_a, 1'b0);
    chk("end_busy_b", busy_b, 1'b0);
    chk("end_done_a", done_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_refire_a", tx_a.o_tx_start, 1'b0);
    chk("no_refire_b", tx_b.o_tx_start, 1'b0);
    chk("len_a", cap_a.size(), exp_a.size());
    chk("len_b", cap_b.size(), exp_b.size());
    for (int i = 0; i < cap_a.size() && i < exp_a.size(); i++)
      chk($sformatf("byte_a[%0d]", i), cap_a[i], exp_a[i]);
    for (int i = 0; i < cap_b.size() && i < exp_b.size(); i++)
      chk($sformatf("byte_b[%0d]", i), cap_b[i], exp_b[i]);
  endtask

  task automatic reset_mid_frame();
    int t;
    @(negedge clk);
    cap_a.delete();
    cap_b.delete();
    i_channels = {$urandom, $urandom, $urandom, $urandom};
    i_ch_mask  = 4'hF;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    t = 0;
    while (cap_a.size() < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("third_byte_seen", cap_a.size(), 3);
    aborted = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_start_a", tx_a.o_tx_start, 1'b0);
    chk("rst_data_a", tx_a.o_tx_data, 8'h00);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    t = 0;
    while (!(idle_a && idle_b) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("resp_idle", idle_a && idle_b, 1'b1);
    repeat (2) @(negedge clk);
    aborted = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    i_start    = 1'b0;
    i_ch_mask  = '0;
    i_channels = '0;
    aborted    = 1'b0;
    dly        = 10;
    repeat (2) @(negedge clk);
    chk("reset_start", tx_a.o_tx_start, 1'b0);
    chk("reset_data", tx_a.o_tx_data, 8'h00);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    run_frame({96'h0, 32'h11223344}, 4'b0001, 1'b0);
    dly = 3;
    run_frame({32'h00000001, 32'hCAFEF00D, 32'hDEADBEEF, 32'h55AA55AA},
              4'b1010, 1'b0);
    run_frame({96'h0, 32'h00000ABC}, 4'b0001, 1'b0);
    run_frame({$urandom, $urandom, $urandom, $urandom}, 4'b0000, 1'b0);
    dly = 8;
    run_frame({$urandom, $urandom, $urandom, $urandom}, 4'b1111, 1'b1);
    dly = 6;
    reset_mid_frame();
    run_frame({$urandom, $urandom, $urandom, $urandom}, 4'b1111, 1'b0);

    for (int n = 0; n < 25; n++) begin
      dly = $urandom_range(1, 12);
      run_frame({$urandom, $urandom, $urandom, $urandom},
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
